pipe_stage_buf: RTL and testbench



---
 rtl/pipe_stage_buf_if.sv | 47 ++++
 rtl/pipe_stage_buf.sv | 192 +++++++++++++++++++
 tb/tb_pipe_stage_buf.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_buf_if.sv
//------------------------------------------------------------------------------
// Module      : pipe_stage_buf_if
// Description : Write/read handshake bundle between a pipeline stage buffer
//               and its neighbouring producer and consumer stages.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pipe_stage_buf_if #(
    parameter int W  = 128,
    parameter int CW = 2
);
    logic          we;
    logic [W-1:0]  w_data;
    logic          wack;
    logic          re;
    logic          rack;
    logic [W-1:0]  r_data;
    logic          avail;
    logic [CW-1:0] count;

    // Requesting side: upstream writer plus downstream reader.
    modport master (
        output we,
        output w_data,
        input  wack,
        output re,
        input  rack,
        input  r_data,
        input  avail,
        input  count
    );

    // Responding side: the buffer itself.
    modport slave (
        input  we,
        input  w_data,
        output wack,
        input  re,
        output rack,
        output r_data,
        output avail,
        output count
    );
endinterface

`default_nettype wire

// File: rtl/pipe_stage_buf.sv
//------------------------------------------------------------------------------
// Module      : pipe_stage_buf
// Description : DEPTH-entry FIFO between two pipeline stages with level
//               request / pulse acknowledge ports and a redirect flush.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_stage_buf #(
    parameter int W     = 128,
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         flush,
    pipe_stage_buf_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [CW-1:0] c_FULL      = CW'(DEPTH);
    localparam logic [CW-1:0] c_CNT_ZERO  = '0;

    // Port state encoding; the reset value doubles as the "armed" flag.
    localparam logic [0:0] c_ST_WAIT_LOW = 1'b0;
    localparam logic [0:0] c_ST_ARMED    = 1'b1;

    //--------------------------------------------------------------------------
    // Storage and registered outputs
    //--------------------------------------------------------------------------
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_avail;
    logic          r_wack;
    logic          r_rack;
    logic [W-1:0]  r_rdata;

    logic [0:0]    r_wr_state;
    logic [0:0]    r_rd_state;

    //--------------------------------------------------------------------------
    // Combinational FSM results
    //--------------------------------------------------------------------------
    logic [0:0]    w_wr_state_nxt;
    logic [0:0]    w_rd_state_nxt;
    logic          w_wr_accept;
    logic          w_rd_accept;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_inc;
    logic [CW-1:0] w_dec;
    logic [CW-1:0] w_count_nxt;

    // Full/empty look only at the pre-edge count: no same-edge bypass.
    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == c_CNT_ZERO);

    //--------------------------------------------------------------------------
    // Write port FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state <= c_ST_ARMED;
        end else begin
            r_wr_state <= w_wr_state_nxt;
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_accept    = 1'b0;
        case (r_wr_state)
            c_ST_ARMED: begin
                if (bus.we && !w_full && !flush) begin
                    w_wr_accept    = 1'b1;
                    w_wr_state_nxt = c_ST_WAIT_LOW;
                end
            end
            c_ST_WAIT_LOW: begin
                // Wait for the requester to drop we so a held level is
                // never captured twice.
                if (!bus.we) begin
                    w_wr_state_nxt = c_ST_ARMED;
                end
            end
            default: begin
                w_wr_state_nxt = c_ST_ARMED;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Read port FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= c_ST_ARMED;
        end else begin
            r_rd_state <= w_rd_state_nxt;
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_accept    = 1'b0;
        case (r_rd_state)
            c_ST_ARMED: begin
                if (bus.re && !w_empty && !flush) begin
                    w_rd_accept    = 1'b1;
                    w_rd_state_nxt = c_ST_WAIT_LOW;
                end
            end
            c_ST_WAIT_LOW: begin
                if (!bus.re) begin
                    w_rd_state_nxt = c_ST_ARMED;
                end
            end
            default: begin
                w_rd_state_nxt = c_ST_ARMED;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Occupancy
    //--------------------------------------------------------------------------
    assign w_inc = {{(CW-1){1'b0}}, w_wr_accept};
    assign w_dec = {{(CW-1){1'b0}}, w_rd_accept};

    always_comb begin
        w_count_nxt = r_count + w_inc - w_dec;
        if (flush) begin
            w_count_nxt = c_CNT_ZERO;
        end
    end

    //--------------------------------------------------------------------------
    // Pointers, count, acks and read data
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_avail <= 1'b0;
            r_wack  <= 1'b0;
            r_rack  <= 1'b0;
            r_rdata <= '0;
        end else begin
            // Acks come straight from acceptance, so a pulse scheduled
            // before a flush still completes and a flush edge raises none.
            r_wack  <= w_wr_accept;
            r_rack  <= w_rd_accept;
            r_count <= w_count_nxt;
            r_avail <= (w_count_nxt != c_CNT_ZERO);
            if (flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_wr_accept) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_rd_accept) begin
                    r_rptr  <= r_rptr + 1'b1;
                    r_rdata <= r_mem[r_rptr];
                end
            end
        end
    end

    // Payload storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_accept) begin
            r_mem[r_wptr] <= bus.w_data;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign bus.wack   = r_wack;
    assign bus.rack   = r_rack;
    assign bus.r_data = r_rdata;
    assign bus.avail  = r_avail;
    assign bus.count  = r_count;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
//------------------------------------------------------------------------------
// Module      : tb_pipe_stage_buf
// Description : Directed self-checking bench for pipe_stage_buf (DEPTH=2).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_stage_buf;

    localparam int W     = 128;
    localparam int DEPTH = 2;
    localparam int CW    = 2;

    logic clk;
    logic rst;
    logic flush;

    int n_checks;
    int n_errors;

    pipe_stage_buf_if #(.W(W), .CW(CW)) bus ();

    pipe_stage_buf #(
        .W     (W),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [W-1:0] data);
        bit seen;
        seen = 1'b0;
        bus.we     = 1'b1;
        bus.w_data = data;
        for (int n = 0; n < 20 && !seen; n++) begin
            step();
            if (bus.wack) seen = 1'b1;
        end
        check_eq("write_ack_seen", {127'd0, seen}, 128'd1);
        bus.we = 1'b0;
        step();
    endtask

    task automatic do_read(input logic [W-1:0] exp);
        bit seen;
        seen = 1'b0;
        bus.re = 1'b1;
        for (int n = 0; n < 20 && !seen; n++) begin
            step();
            if (bus.rack) seen = 1'b1;
        end
        check_eq("read_ack_seen", {127'd0, seen}, 128'd1);
        check_eq("read_data", bus.r_data, exp);
        bus.re = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        flush      = 1'b0;
        bus.we     = 1'b0;
        bus.re     = 1'b0;
        bus.w_data = '0;
        step();
        step();

        check_eq("rst_wack",  {127'd0, bus.wack},  128'd0);
        check_eq("rst_rack",  {127'd0, bus.rack},  128'd0);
        check_eq("rst_avail", {127'd0, bus.avail}, 128'd0);
        check_eq("rst_count", {126'd0, bus.count}, 128'd0);
        check_eq("rst_rdata", bus.r_data,          128'd0);
        rst = 1'b0;

        // 1: single transfer
        bus.we = 1'b1; bus.w_data = 128'hA5;
        step();
        check_eq("t1_wack",  {127'd0, bus.wack},  128'd1);
        check_eq("t1_count", {126'd0, bus.count}, 128'd1);
        check_eq("t1_avail", {127'd0, bus.avail}, 128'd1);
        bus.we = 1'b0;
        step();
        check_eq("t1_wack_pulse", {127'd0, bus.wack}, 128'd0);
        bus.re = 1'b1;
        step();
        check_eq("t1_rack",   {127'd0, bus.rack},  128'd1);
        check_eq("t1_rdata",  bus.r_data,          128'hA5);
        check_eq("t1_count0", {126'd0, bus.count}, 128'd0);
        check_eq("t1_avail0", {127'd0, bus.avail}, 128'd0);
        bus.re = 1'b0;
        step();
        check_eq("t1_rack_pulse", {127'd0, bus.rack}, 128'd0);

        // 2: fill and stall
        do_write(128'h1);
        do_write(128'h2);
        check_eq("t2_full_count", {126'd0, bus.count}, 128'd2);
        bus.we = 1'b1; bus.w_data = 128'h3;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t2_stall_wack",  {127'd0, bus.wack},  128'd0);
            check_eq("t2_stall_count", {126'd0, bus.count}, 128'd2);
        end
        bus.re = 1'b1;
        step();
        check_eq("t2_rack",      {127'd0, bus.rack},  128'd1);
        check_eq("t2_rdata1",    bus.r_data,          128'h1);
        check_eq("t2_no_bypass", {127'd0, bus.wack},  128'd0);
        check_eq("t2_count1",    {126'd0, bus.count}, 128'd1);
        bus.re = 1'b0;
        step();
        check_eq("t2_late_wack", {127'd0, bus.wack},  128'd1);
        check_eq("t2_count2",    {126'd0, bus.count}, 128'd2);
        bus.we = 1'b0;
        step();
        do_read(128'h2);
        do_read(128'h3);
        check_eq("t2_empty", {126'd0, bus.count}, 128'd0);

        // Empty read is held without an ack
        bus.re = 1'b1;
        step();
        step();
        check_eq("empty_no_rack", {127'd0, bus.rack}, 128'd0);
        bus.re = 1'b0;
        step();

        // 3: held write is captured once
        bus.we = 1'b1; bus.w_data = 128'h55;
        step();
        check_eq("t3_wack", {127'd0, bus.wack}, 128'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t3_held_wack",  {127'd0, bus.wack},  128'd0);
            check_eq("t3_held_count", {126'd0, bus.count}, 128'd1);
        end
        bus.we = 1'b0;
        step();
        bus.we = 1'b1; bus.w_data = 128'h66;
        step();
        check_eq("t3_rewrite_wack",  {127'd0, bus.wack},  128'd1);
        check_eq("t3_rewrite_count", {126'd0, bus.count}, 128'd2);
        bus.we = 1'b0;
        step();
        do_read(128'h55);
        do_read(128'h66);

        // 4: simultaneous read/write with count=1, 8 transfers across wrap
        do_write(128'h10);
        for (int i = 0; i < 8; i++) begin
            bus.we = 1'b1; bus.re = 1'b1;
            bus.w_data = 128'h20 + 128'(i);
            step();
            check_eq("t4_wack",  {127'd0, bus.wack},  128'd1);
            check_eq("t4_rack",  {127'd0, bus.rack},  128'd1);
            check_eq("t4_count", {126'd0, bus.count}, 128'd1);
            check_eq("t4_rdata", bus.r_data, (i == 0) ? 128'h10 : 128'h20 + 128'(i - 1));
            bus.we = 1'b0; bus.re = 1'b0;
            step();
        end
        do_read(128'h27);

        // 5: flush with a held read
        do_write(128'hA);
        do_write(128'hB);
        bus.re = 1'b1; flush = 1'b1;
        step();
        check_eq("t5_flush_rack",  {127'd0, bus.rack},  128'd0);
        check_eq("t5_flush_count", {126'd0, bus.count}, 128'd0);
        check_eq("t5_flush_avail", {127'd0, bus.avail}, 128'd0);
        check_eq("t5_rdata_kept",  bus.r_data,          128'h27);
        flush = 1'b0;
        step();
        check_eq("t5_empty_rack", {127'd0, bus.rack}, 128'd0);
        bus.we = 1'b1; bus.w_data = 128'h7;
        step();
        check_eq("t5_wack",  {127'd0, bus.wack},  128'd1);
        check_eq("t5_count", {126'd0, bus.count}, 128'd1);
        bus.we = 1'b0;
        step();
        check_eq("t5_rack",  {127'd0, bus.rack}, 128'd1);
        check_eq("t5_rdata", bus.r_data,         128'h7);
        check_eq("t5_count0", {126'd0, bus.count}, 128'd0);
        bus.re = 1'b0;
        step();

        // 6: reset during the wack cycle
        do_write(128'hD1);
        bus.we = 1'b1; bus.w_data = 128'h99;
        step();
        check_eq("t6_wack",  {127'd0, bus.wack},  128'd1);
        check_eq("t6_count", {126'd0, bus.count}, 128'd2);
        rst = 1'b1; bus.we = 1'b0;
        step();
        check_eq("t6_rst_wack",  {127'd0, bus.wack},  128'd0);
        check_eq("t6_rst_count", {126'd0, bus.count}, 128'd0);
        check_eq("t6_rst_avail", {127'd0, bus.avail}, 128'd0);
        check_eq("t6_rst_rdata", bus.r_data,          128'd0);
        rst = 1'b0;
        bus.we = 1'b1; bus.w_data = 128'hC3;
        step();
        check_eq("t6_post_wack",  {127'd0, bus.wack},  128'd1);
        check_eq("t6_post_count", {126'd0, bus.count}, 128'd1);
        bus.we = 1'b0;
        step();
        do_read(128'hC3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
